// File: rtl/rf_wb_sched_if.sv
// Write-back request bundle for rf_wb_sched.
// Requester 0 is the in-order pipeline write-back.
// Requester 1 is the long-latency unit (mul/div/load).
// The master drives valid/addr/data. The scheduler (slave) returns ready.
interface rf_wb_sched_if;
  logic        wb0_valid;
  logic [4:0]  wb0_addr;
  logic [31:0] wb0_data;
  logic        wb0_ready;
  logic        wb1_valid;
  logic [4:0]  wb1_addr;
  logic [31:0] wb1_data;
  logic        wb1_ready;

  modport master (
    output wb0_valid, wb0_addr, wb0_data,
    input  wb0_ready,
    output wb1_valid, wb1_addr, wb1_data,
    input  wb1_ready
  );

  modport slave (
    input  wb0_valid, wb0_addr, wb0_data,
    output wb0_ready,
    input  wb1_valid, wb1_addr, wb1_data,
    output wb1_ready
  );
endinterface

// File: rtl/rf_wb_sched.sv
// rf_wb_sched: write-back scheduler and scoreboard for the 32x32 register file.
// - Arbitrates the single register-file write port between the pipeline (wb0)
//   and the long-latency unit (wb1), with anti-starvation for wb1.
// - Tracks registers with outstanding long-latency results (busy bits).
// - Raises WAW issue stalls and read-hazard stalls toward decode.
// Optional feature macro RF_WB_BYPASS_EN: when defined, a decode source that
// matches the staged write is forwarded from rf_wdata instead of stalling.
module rf_wb_sched #(
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic        clk,
  input  logic        resetn,
  rf_wb_sched_if.slave wb,
  input  logic        iss_valid,
  input  logic [4:0]  iss_addr,
  output logic        iss_stall,
  input  logic [4:0]  chk_addr1,
  input  logic [4:0]  chk_addr2,
  output logic        rd_stall,
  output logic        fwd1_en,
  output logic [31:0] fwd1_data,
  output logic        fwd2_en,
  output logic [31:0] fwd2_data,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata
);

  localparam int unsigned DATA_W = 32;
  localparam logic [3:0]  STARVE_LIM = 4'(STARVE_MAX);

  // Saturating increment of the starve counter.
  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v >= STARVE_LIM) ? STARVE_LIM : v + 4'd1;
  endfunction

  // Evaluate one decode source: returns {stall, forward}.
  function automatic logic [1:0] src_eval(input logic [4:0]  a,
                                          input logic [31:0] bz,
                                          input logic        we,
                                          input logic [4:0]  wa);
    logic used, pend, stg;
    used = (a != 5'd0);
    pend = used && bz[a];
    stg  = used && we && (wa == a) && !pend;
`ifdef RF_WB_BYPASS_EN
    return {pend, stg};
`else
    return {pend || stg, 1'b0};
`endif
  endfunction

  logic [3:0]        cnt;
  logic [31:0]       busy;
  logic              vld_p1;
  logic [4:0]        waddr_p1;
  logic [DATA_W-1:0] wdata_p1;

  logic              wb0_nz, wb0_zero, wb1_nz, wb1_zero;
  logic              gnt0_p0, gnt1_p0, acc0_p0, acc1_p0;
  logic              vld_p0;
  logic [4:0]        waddr_p0;
  logic [DATA_W-1:0] wdata_p0;
  logic              iss_hit;
  logic [31:0]       set_mask, clr_mask;
  logic [1:0]        src1, src2;

  // ---- stage p0: arbitration, acceptance and scoreboard next-state ----
  // Port arbitration; r0 writes are accepted without using the port.
  always_comb begin
    wb0_nz   = wb.wb0_valid && (wb.wb0_addr != 5'd0);
    wb0_zero = wb.wb0_valid && (wb.wb0_addr == 5'd0);
    wb1_nz   = wb.wb1_valid && (wb.wb1_addr != 5'd0);
    wb1_zero = wb.wb1_valid && (wb.wb1_addr == 5'd0);
    gnt1_p0  = wb1_nz && (!wb0_nz || (cnt == STARVE_LIM));
    gnt0_p0  = wb0_nz && !gnt1_p0;
    acc0_p0  = resetn && (wb0_zero || gnt0_p0);
    acc1_p0  = resetn && (wb1_zero || gnt1_p0);
    vld_p0   = gnt0_p0 || gnt1_p0;
    waddr_p0 = gnt1_p0 ? wb.wb1_addr : wb.wb0_addr;
    wdata_p0 = gnt1_p0 ? wb.wb1_data : wb.wb0_data;
  end

  assign wb.wb0_ready = acc0_p0;
  assign wb.wb1_ready = acc1_p0;

  // Scoreboard set/clear masks; a set in the same cycle as a clear wins.
  always_comb begin
    iss_hit   = iss_valid && (iss_addr != 5'd0);
    iss_stall = resetn && iss_hit && busy[iss_addr];
    set_mask  = (iss_hit && !busy[iss_addr]) ? (32'd1 << iss_addr) : 32'd0;
    clr_mask  = (acc1_p0 && wb1_nz) ? (32'd1 << wb.wb1_addr) : 32'd0;
  end

  // Starve counter: counts consecutive cycles wb1 loses the port.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt <= 4'd0;
    end else if (!wb.wb1_valid || acc1_p0) begin
      cnt <= 4'd0;
    end else begin
      cnt <= sat_inc(cnt);
    end
  end

  // Busy bits for registers awaiting a long-latency result.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      busy <= 32'd0;
    end else begin
      busy <= (busy & ~clr_mask) | set_mask;
    end
  end

  // ---- stage p1: registered register-file write ----
  // Stage the granted write; address/data hold when nothing is granted.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      vld_p1   <= 1'b0;
      waddr_p1 <= 5'd0;
      wdata_p1 <= '0;
    end else begin
      vld_p1 <= vld_p0;
      if (vld_p0) begin
        waddr_p1 <= waddr_p0;
        wdata_p1 <= wdata_p0;
      end
    end
  end

  assign rf_we    = vld_p1;
  assign rf_waddr = waddr_p1;
  assign rf_wdata = wdata_p1;

  // Decode read-hazard and forwarding evaluation for both sources.
  always_comb begin
    src1      = resetn ? src_eval(chk_addr1, busy, vld_p1, waddr_p1) : 2'b00;
    src2      = resetn ? src_eval(chk_addr2, busy, vld_p1, waddr_p1) : 2'b00;
    rd_stall  = src1[1] || src2[1];
    fwd1_en   = src1[0];
    fwd2_en   = src2[0];
    fwd1_data = src1[0] ? wdata_p1 : '0;
    fwd2_data = src2[0] ? wdata_p1 : '0;
  end

endmodule

// File: tb/tb_rf_wb_sched.sv
// Testbench for rf_wb_sched: directed vectors with a behavioural model and
// a per-cycle compare process, plus hand-computed literal expectations.
module tb_rf_wb_sched;
  localparam int SMAX = 3;
`ifdef RF_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        resetn;
  logic        iss_valid;
  logic [4:0]  iss_addr, chk_addr1, chk_addr2;
  logic        iss_stall, rd_stall, fwd1_en, fwd2_en, rf_we;
  logic [31:0] fwd1_data, fwd2_data, rf_wdata;
  logic [4:0]  rf_waddr;

  always #5 clk = ~clk;

  rf_wb_sched_if bus();

  rf_wb_sched #(.STARVE_MAX(SMAX)) dut (
    .clk(clk), .resetn(resetn), .wb(bus),
    .iss_valid(iss_valid), .iss_addr(iss_addr), .iss_stall(iss_stall),
    .chk_addr1(chk_addr1), .chk_addr2(chk_addr2), .rd_stall(rd_stall),
    .fwd1_en(fwd1_en), .fwd1_data(fwd1_data),
    .fwd2_en(fwd2_en), .fwd2_data(fwd2_data),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
  );

  int n_checks = 0;
  int n_errs   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_busy;
  int          m_cnt;
  logic        m_we;
  logic [4:0]  m_waddr;
  logic [31:0] m_wdata;
  logic [31:0] m_rf [32];

  // Which requests are accepted this cycle under the arbitration rules.
  function automatic void m_accept(output bit a0, output bit a1);
    bit nz0, nz1;
    a0 = 0; a1 = 0;
    if (!resetn) return;
    nz0 = bus.wb0_valid && bus.wb0_addr != 0;
    nz1 = bus.wb1_valid && bus.wb1_addr != 0;
    if (bus.wb0_valid && bus.wb0_addr == 0) a0 = 1;
    if (bus.wb1_valid && bus.wb1_addr == 0) a1 = 1;
    if (nz0 && nz1) begin
      if (m_cnt == SMAX) a1 = 1; else a0 = 1;
    end else if (nz0) a0 = 1;
    else if (nz1) a1 = 1;
  endfunction

  // Decode source readability.
  function automatic void m_src(input logic [4:0] a, output bit st, output bit en);
    st = 0; en = 0;
    if (!resetn || a == 0) return;
    if (m_busy[a]) st = 1;
    else if (m_we && m_waddr == a) begin
      if (BYP) en = 1; else st = 1;
    end
  endfunction

  always @(posedge clk or negedge resetn) begin
    bit a0, a1;
    logic [31:0] nb;
    if (!resetn) begin
      m_busy  <= '0;
      m_cnt   <= 0;
      m_we    <= 1'b0;
      m_waddr <= '0;
      m_wdata <= '0;
      for (int i = 0; i < 32; i++) m_rf[i] <= '0;
    end else begin
      m_accept(a0, a1);
      if (a0 && bus.wb0_addr != 0) begin
        m_we <= 1'b1; m_waddr <= bus.wb0_addr; m_wdata <= bus.wb0_data;
      end else if (a1 && bus.wb1_addr != 0) begin
        m_we <= 1'b1; m_waddr <= bus.wb1_addr; m_wdata <= bus.wb1_data;
      end else begin
        m_we <= 1'b0;
      end
      if (m_we) m_rf[m_waddr] <= m_wdata;
      if (!bus.wb1_valid || a1) m_cnt <= 0;
      else m_cnt <= (m_cnt + 1 > SMAX) ? SMAX : m_cnt + 1;
      nb = m_busy;
      if (a1 && bus.wb1_addr != 0) nb[bus.wb1_addr] = 1'b0;
      if (iss_valid && iss_addr != 0 && !m_busy[iss_addr]) nb[iss_addr] = 1'b1;
      m_busy <= nb;
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    bit a0, a1, s1, e1, s2, e2, ist;
    m_accept(a0, a1);
    m_src(chk_addr1, s1, e1);
    m_src(chk_addr2, s2, e2);
    ist = resetn && iss_valid && iss_addr != 0 && m_busy[iss_addr];
    check("wb0_ready", bus.wb0_ready, a0);
    check("wb1_ready", bus.wb1_ready, a1);
    check("iss_stall", iss_stall, ist);
    check("rd_stall", rd_stall, s1 | s2);
    check("fwd1_en", fwd1_en, e1);
    check("fwd2_en", fwd2_en, e2);
    if (e1 || !BYP) check("fwd1_data", fwd1_data, e1 ? m_wdata : 32'd0);
    if (e2 || !BYP) check("fwd2_data", fwd2_data, e2 ? m_wdata : 32'd0);
    check("rf_we", rf_we, m_we);
    check("rf_waddr", rf_waddr, m_waddr);
    check("rf_wdata", rf_wdata, m_wdata);
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    bus.wb0_valid = 0; bus.wb1_valid = 0;
    iss_valid = 0; chk_addr1 = 0; chk_addr2 = 0;
  endtask

  initial begin
    resetn = 0;
    bus.wb0_valid = 1; bus.wb0_addr = 5'd3; bus.wb0_data = 32'h33;
    bus.wb1_valid = 1; bus.wb1_addr = 5'd4; bus.wb1_data = 32'h44;
    iss_valid = 0; iss_addr = 0; chk_addr1 = 0; chk_addr2 = 0;

    // Reset holds both readies low even with valid requests.
    repeat (2) @(posedge clk);
    #2;
    check("rst_rdy0", bus.wb0_ready, 0);
    check("rst_rdy1", bus.wb1_ready, 0);
    check("rst_we", rf_we, 0);

    // Release: wb0 wins 3 times, then wb1 after starving.
    @(posedge clk); #1 resetn = 1; #1;
    check("arb_a_rdy0", bus.wb0_ready, 1);
    check("arb_a_rdy1", bus.wb1_ready, 0);
    tick(); #1;
    check("arb_b_rdy0", bus.wb0_ready, 1);
    tick(); #1;
    check("arb_c_rdy0", bus.wb0_ready, 1);
    check("arb_c_rdy1", bus.wb1_ready, 0);
    tick(); #1;
    check("arb_d_rdy1", bus.wb1_ready, 1);
    check("arb_d_rdy0", bus.wb0_ready, 0);
    check("arb_d_waddr", rf_waddr, 3);
    tick(); #1;
    check("arb_e_rdy0", bus.wb0_ready, 1);
    check("arb_e_rdy1", bus.wb1_ready, 0);
    check("arb_e_waddr", rf_waddr, 4);
    check("arb_e_wdata", rf_wdata, 32'h44);
    check("mdl_cnt", m_cnt, 0);
    idle();
    tick(); tick();

    // Single wb0 write to r5.
    bus.wb0_valid = 1; bus.wb0_addr = 5'd5; bus.wb0_data = 32'h1234; #1;
    check("w5_rdy", bus.wb0_ready, 1);
    tick(); idle(); #1;
    check("w5_we", rf_we, 1);
    check("w5_waddr", rf_waddr, 5);
    check("w5_wdata", rf_wdata, 32'h1234);
    tick(); #1;
    check("w5_we_off", rf_we, 0);
    check("w5_hold", rf_waddr, 5);

    // wb0 to r7 with wb1 to r0 in the same cycle.
    bus.wb0_valid = 1; bus.wb0_addr = 5'd7; bus.wb0_data = 32'hA;
    bus.wb1_valid = 1; bus.wb1_addr = 5'd0; bus.wb1_data = 32'hB; #1;
    check("r0_rdy0", bus.wb0_ready, 1);
    check("r0_rdy1", bus.wb1_ready, 1);
    tick(); idle(); #1;
    check("r0_we", rf_we, 1);
    check("r0_waddr", rf_waddr, 7);
    check("r0_wdata", rf_wdata, 32'hA);
    tick(); #1;
    check("r0_we_off", rf_we, 0);
    check("mdl_rf7", m_rf[7], 32'hA);
    check("mdl_rf0", m_rf[0], 32'h0);

    // Issue r9, read-hazard until the long-latency result arrives.
    iss_valid = 1; iss_addr = 5'd9; #1;
    check("iss9_stall", iss_stall, 0);
    tick(); idle(); chk_addr1 = 5'd9; chk_addr2 = 5'd9; #1;
    check("haz9_stall", rd_stall, 1);
    bus.wb1_valid = 1; bus.wb1_addr = 5'd9; bus.wb1_data = 32'h55; #1;
    check("haz9_rdy1", bus.wb1_ready, 1);
    tick(); bus.wb1_valid = 0; #1;
    check("stg9_stall", rd_stall, !BYP);
    check("stg9_fwd1", fwd1_en, BYP);
    check("stg9_fwd2", fwd2_en, BYP);
    check("stg9_fdata", fwd1_data, BYP ? 32'h55 : 32'h0);
    tick(); #1;
    check("done9_stall", rd_stall, 0);
    check("done9_fwd", fwd1_en, 0);
    idle();

    // r9 busy: issue r9 while wb1 clears it -> WAW stall and busy clears.
    iss_valid = 1; iss_addr = 5'd9;
    tick(); #1;
    bus.wb1_valid = 1; bus.wb1_addr = 5'd9; bus.wb1_data = 32'h66; #1;
    check("waw_stall", iss_stall, 1);
    check("waw_rdy1", bus.wb1_ready, 1);
    tick(); idle(); chk_addr1 = 5'd9; #1;
    check("waw_stg_stall", rd_stall, !BYP);
    check("waw_stg_fdata", fwd1_data, BYP ? 32'h66 : 32'h0);
    tick(); #1;
    check("waw_clr_stall", rd_stall, 0);

    // r9 free: issue r9 and wb1 clear of r9 in one cycle -> set wins.
    chk_addr1 = 0;
    iss_valid = 1; iss_addr = 5'd9;
    bus.wb1_valid = 1; bus.wb1_addr = 5'd9; bus.wb1_data = 32'h77; #1;
    check("setwin_iss", iss_stall, 0);
    check("setwin_rdy1", bus.wb1_ready, 1);
    tick(); idle(); chk_addr1 = 5'd9; #1;
    check("setwin_stall", rd_stall, 1);
    check("setwin_fwd", fwd1_en, 0);
    tick(); #1;
    check("setwin_stall2", rd_stall, 1);
    chk_addr1 = 0;
    bus.wb1_valid = 1; bus.wb1_addr = 5'd9; bus.wb1_data = 32'h78;
    tick(); idle(); tick(); chk_addr1 = 5'd9; #1;
    check("setwin_clr", rd_stall, 0);
    idle();

    // Reset mid-operation: staged write and busy bits are discarded.
    iss_valid = 1; iss_addr = 5'd12;
    bus.wb0_valid = 1; bus.wb0_addr = 5'd6; bus.wb0_data = 32'h66;
    tick(); idle(); #1;
    check("mid_we_pre", rf_we, 1);
    resetn = 0; #1;
    check("mid_we", rf_we, 0);
    check("mid_waddr", rf_waddr, 0);
    check("mid_wdata", rf_wdata, 0);
    @(posedge clk); #1 resetn = 1; chk_addr1 = 5'd12; #1;
    check("mid_busy_lost", rd_stall, 0);
    tick(); idle(); tick();

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end
endmodule
